// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants, the in-flight tag type and the round-robin pick helper
// used by the AES request scheduler and its arbiter.
// Contents:
//   AES_DW        block/key width
//   AES_CORE_LAT  latency of the shared AES-128 core
//   AES_MAX_REQ   largest supported requester count
//   AES_MAX_IDW   id width that covers AES_MAX_REQ requesters
//   tag_t         {vld, id} carried alongside each block in the core
//   rr_pick       one-hot round-robin grant starting at a pointer
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_DW       = 128;
  localparam int AES_CORE_LAT = 11;
  localparam int AES_MAX_REQ  = 8;
  localparam int AES_MAX_IDW  = 3;

  // The id field is sized for the largest configuration so the type does not
  // depend on the scheduler's parameters; narrower builds use the low bits.
  typedef struct packed {
    logic                   vld;
    logic [AES_MAX_IDW-1:0] id;
  } tag_t;

  // Scans n requesters starting at ptr with wrap; the first one asserting
  // req wins. Bits at or above n are never granted.
  function automatic logic [AES_MAX_REQ-1:0] rr_pick(
    input logic [AES_MAX_REQ-1:0] req,
    input logic [AES_MAX_IDW-1:0] ptr,
    input int unsigned            n
  );
    logic [AES_MAX_REQ-1:0] grant;
    logic                   found;
    logic [31:0]            idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < AES_MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if ((k < n) && !found && req[idx[2:0]]) begin
        grant[idx[2:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/aes_req_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant plus the rotating priority pointer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          request vector, one bit per requester
//   grant        one-hot grant (all zero while in reset or nothing requested)
//   grant_id     index of the granted requester
//   grant_vld    a grant is given this cycle (a handshake happens at the edge)
// ---------------------------------------------------------------------------
module rr_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               grant_vld
);

  logic [IDW-1:0]         ptr;
  logic [AES_MAX_REQ-1:0] req_ext;
  logic [AES_MAX_REQ-1:0] pick;

  // Grants are suppressed during reset so nothing is accepted while the
  // pipeline is being cleared.
  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    pick      = rr_pick(req_ext, AES_MAX_IDW'(ptr), NUM_REQ);
    grant     = rst_n ? pick[NUM_REQ-1:0] : '0;
    grant_vld = rst_n & (|pick);
    grant_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  // The winner drops to lowest priority by moving the pointer just past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);
    end
  end

endmodule

// File: rtl/aes_req_scheduler.sv
// ---------------------------------------------------------------------------
// aes_req_scheduler
// Shares one fully pipelined AES-128 core between NUM_REQ requesters. One
// block per cycle is granted round-robin, registered onto the core inputs and
// tagged with its requester id; the tag travels beside the block so the
// ciphertext can be returned with the id that produced it.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (req_ready is one-hot)
//   req_pt, req_key        packed plaintexts/keys, requester i at [i*DW +: DW]
//   core_p, core_k         registered block/key into the core
//   core_c, core_valid     ciphertext and pipeline-filled flag from the core
//   rsp_valid/id/ct        one-cycle response pulse with id and ciphertext
//   busy                   a tag is in flight or a response is being shown
//   err                    sticky: a result was due while core_valid was low
// ---------------------------------------------------------------------------
module aes_req_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LAT     = AES_CORE_LAT,
  parameter int DW      = AES_DW,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_pt,
  input  logic [NUM_REQ*DW-1:0] req_key,
  output logic [DW-1:0]         core_p,
  output logic [DW-1:0]         core_k,
  input  logic [DW-1:0]         core_c,
  input  logic                  core_valid,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [DW-1:0]         rsp_ct,
  output logic                  busy,
  output logic                  err
);

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               grant_vld;
  logic [DW-1:0]      sel_pt;
  logic [DW-1:0]      sel_key;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  assign req_ready = grant;

  // One-hot grant drives a simple AND-OR select of the winning block.
  always_comb begin
    sel_pt  = '0;
    sel_key = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_pt  = req_pt[i*DW +: DW];
        sel_key = req_key[i*DW +: DW];
      end
    end
  end

  // Core inputs keep their last value when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_p <= '0;
      core_k <= '0;
    end else if (grant_vld) begin
      core_p <= sel_pt;
      core_k <= sel_key;
    end
  end

  // tag_q[0] sits beside the core_p/core_k register; tag_q[1..LAT] follow the
  // block through the core's LAT edges, so tag_q[LAT] is valid exactly while
  // core_c holds that block's ciphertext. The shift never stalls.
  tag_t tag_q [LAT+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{vld: grant_vld, id: AES_MAX_IDW'(grant_id)};
      for (int s = 1; s <= LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Capture the core output only when a tag is due; a missing core_valid is
  // flagged but the response still goes out so the requester is not starved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_ct    <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= tag_q[LAT].vld;
      if (tag_q[LAT].vld) begin
        rsp_id <= tag_q[LAT].id[IDW-1:0];
        rsp_ct <= core_c;
        if (!core_valid) err <= 1'b1;
      end
    end
  end

  always_comb begin
    busy = rsp_valid;
    for (int s = 0; s <= LAT; s++) busy = busy | tag_q[s].vld;
  end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_req_scheduler
// Directed bench for aes_req_scheduler with a behavioural AES-128 core model
// (LAT = 11 edges from core_p/core_k sampling to core_c). A scoreboard records
// every handshake with the reference ciphertext and checks each response.
// ---------------------------------------------------------------------------
module tb_aes_req_scheduler;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 11;
  localparam int DW      = 128;
  localparam int IDW     = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_pt;
  logic [NUM_REQ*DW-1:0] req_key;
  logic [DW-1:0]         core_p;
  logic [DW-1:0]         core_k;
  logic [DW-1:0]         core_c;
  logic                  core_valid;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [DW-1:0]         rsp_ct;
  logic                  busy;
  logic                  err;

  int errors = 0;
  int checks = 0;
  int rspCount = 0;

  aes_req_scheduler #(
    .NUM_REQ (NUM_REQ),
    .LAT     (LAT),
    .DW      (DW),
    .IDW     (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pt     (req_pt),
    .req_key    (req_key),
    .core_p     (core_p),
    .core_k     (core_k),
    .core_c     (core_c),
    .core_valid (core_valid),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_ct     (rsp_ct),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic initSbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0) begin
        for (int b = 1; b < 256; b++) begin
          if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
        end
      end
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = sbox[s[127-8*n -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aesEncrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] st;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      st = shiftRows(subBytes(st));
      if (r != 10) st = mixColumns(st);
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  // Core model: samples core_p/core_k every edge, result on core_c LAT edges later.
  logic [127:0] corePipe [LAT];
  always @(posedge clk) begin
    corePipe[0] <= aesEncrypt(core_p, core_k);
    for (int s = 1; s < LAT; s++) corePipe[s] <= corePipe[s-1];
  end
  assign core_c = corePipe[LAT-1];

  // ---------------- checking ----------------
  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [127:0]   ct;
  } exp_t;
  exp_t expQ[$];

  // Scoreboard on the falling edge: inputs and registered outputs are stable.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      expQ.delete();
    end else begin
      if (rsp_valid) begin
        rspCount++;
        if (expQ.size() == 0) begin
          checkOutput("rsp_unexpected", 128'(rsp_valid), 128'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_id", 128'(rsp_id), 128'(e.id));
          checkOutput("rsp_ct", rsp_ct, e.ct);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i])
          expQ.push_back('{id: IDW'(i), ct: aesEncrypt(req_pt[i*DW +: DW], req_key[i*DW +: DW])});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_pt[i*DW +: DW]  = {$urandom, $urandom, $urandom, $urandom};
      req_key[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
    end
    req_valid = v;
  endtask

  task automatic applyReset();
    req_valid = '0;
    rst_n     = 1'b0;
    waitCycle();
    waitCycle();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 60 && expQ.size() != 0; c++) waitCycle();
    waitCycle();
    checkOutput(tag, 128'(expQ.size()), 128'd0);
  endtask

  int startCnt;
  int issued;

  initial begin
    initSbox();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_pt     = '0;
    req_key    = '0;
    core_valid = 1'b1;

    // Reset state, with requests pending so the grant gating is visible
    req_valid = 4'b1111;
    #1;
    checkOutput("rst_ready", 128'(req_ready), 128'd0);
    waitCycle();
    checkOutput("rst_core_p", core_p, 128'd0);
    checkOutput("rst_core_k", core_k, 128'd0);
    checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    checkOutput("rst_rsp_id", 128'(rsp_id), 128'd0);
    checkOutput("rst_rsp_ct", rsp_ct, 128'd0);
    checkOutput("rst_err", 128'(err), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    waitCycle();

    // 1: single FIPS-197 block from requester 2
    req_pt[2*DW +: DW]  = 128'h3243f6a8885a308d313198a2e0370734;
    req_key[2*DW +: DW] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    req_valid = 4'b0100;
    #1;
    checkOutput("t1_ready", 128'(req_ready), 128'h4);
    waitCycle();
    req_valid = '0;
    checkOutput("t1_core_p", core_p, 128'h3243f6a8885a308d313198a2e0370734);
    checkOutput("t1_core_k", core_k, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    checkOutput("t1_busy", 128'(busy), 128'd1);
    repeat (LAT) waitCycle();
    checkOutput("t1_rsp_early", 128'(rsp_valid), 128'd0);
    waitCycle();
    checkOutput("t1_rsp_valid", 128'(rsp_valid), 128'd1);
    checkOutput("t1_rsp_id", 128'(rsp_id), 128'd2);
    checkOutput("t1_rsp_ct", rsp_ct, 128'h3925841d02dc09fbdc118597196a0b32);
    waitCycle();
    checkOutput("t1_rsp_pulse", 128'(rsp_valid), 128'd0);
    checkOutput("t1_busy_idle", 128'(busy), 128'd0);

    // 2: all requesters persistent for 8 cycles from pointer 0
    applyReset();
    startCnt = rspCount;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111);
      #1;
      checkOutput($sformatf("t2_grant%0d", k), 128'(req_ready), 128'(4'b0001 << (k % 4)));
      waitCycle();
    end
    req_valid = '0;
    drain("t2_drain");
    checkOutput("t2_rsp_count", 128'(rspCount - startCnt), 128'd8);

    // 3: only requesters 0 and 2 -> strict alternation
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0101);
      #1;
      checkOutput($sformatf("t3_grant%0d", k), 128'(req_ready), (k % 2 == 0) ? 128'h1 : 128'h4);
      waitCycle();
    end
    req_valid = '0;
    drain("t3_drain");

    // 4: reset while blocks are in flight
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1111);
      waitCycle();
    end
    rst_n = 1'b0;
    #1;
    checkOutput("t4_ready_in_rst", 128'(req_ready), 128'd0);
    waitCycle();
    waitCycle();
    req_valid = '0;
    rst_n     = 1'b1;
    #1;
    checkOutput("t4_busy_release", 128'(busy), 128'd0);
    for (int k = 0; k < LAT + 2; k++) begin
      waitCycle();
      checkOutput($sformatf("t4_no_rsp%0d", k), 128'(rsp_valid), 128'd0);
    end
    checkOutput("t4_busy", 128'(busy), 128'd0);
    req_valid = 4'b1111;
    #1;
    checkOutput("t4_ptr0", 128'(req_ready), 128'h1);
    req_valid = '0;
    waitCycle();

    // 5: core_valid low while a tag reaches the tail
    checkOutput("t5_err_before", 128'(err), 128'd0);
    core_valid = 1'b0;
    applyStimulus(4'b0010);
    waitCycle();
    req_valid = '0;
    repeat (LAT + 1) waitCycle();
    checkOutput("t5_rsp_valid", 128'(rsp_valid), 128'd1);
    checkOutput("t5_rsp_id", 128'(rsp_id), 128'd1);
    checkOutput("t5_err_set", 128'(err), 128'd1);
    core_valid = 1'b1;
    repeat (5) waitCycle();
    checkOutput("t5_err_sticky", 128'(err), 128'd1);

    // 6: 100 random blocks across random requesters
    applyReset();
    checkOutput("t6_err_cleared", 128'(err), 128'd0);
    startCnt = rspCount;
    issued   = 0;
    for (int c = 0; c < 1000 && issued < 100; c++) begin
      applyStimulus(4'($urandom_range(1, 15)));
      #1;
      if (|(req_valid & req_ready)) issued++;
      waitCycle();
    end
    req_valid = '0;
    drain("t6_drain");
    checkOutput("t6_issued", 128'(issued), 128'd100);
    checkOutput("t6_rsp_count", 128'(rspCount - startCnt), 128'd100);
    checkOutput("t6_err", 128'(err), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
